// File: rtl/log_arb_pkg.sv
// Shared types and constants for the two-requester logic-unit arbiter.
package log_arb_pkg;

    // Arbiter FSM states; anything other than ST_IDLE counts as busy.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } log_arb_state_e;

    // Request op codes, written as {op[1], op[0]} = {AluOp1, AluOp0}.
    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_NOR = 2'b10;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b11;

    // Maps a request op code onto the {AluOp1, AluOp0} control pair of the logic unit.
    function automatic logic [1:0] alu_ctl(input logic [1:0] op);
        logic [1:0] ctl;
        ctl = 2'b00;
        case (op)
            OP_OR:   ctl = 2'b00;
            OP_NOR:  ctl = 2'b10;
            OP_AND:  ctl = 2'b01;
            OP_XOR:  ctl = 2'b11;
            default: ctl = 2'b00;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/log_rr_pick.sv
// Two-way round-robin pick: on a tie the requester not granted last wins,
// a lone valid requester always wins.
module log_rr_pick
    import log_arb_pkg::*;
(
    input  logic [1:0] valids,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    // Combinational grant selection from the current valids and grant history.
    always_comb begin
        grant_valid = |valids;
        grant_id    = 1'b0;
        if (valids == 2'b11) begin
            grant_id = ~last_grant;
        end else if (valids[1]) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/log_arbiter.sv
// Arbitrates two requesters onto one shared combinational logic unit.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready may depend combinationally on valid, valid must not depend
// on ready. One operation is in flight at a time: IDLE -> EXEC -> RESP.
module log_arbiter
    import log_arb_pkg::*;
#(
    parameter int          W             = 32,
    // Value op_count takes at reset; normally 0.
    parameter logic [15:0] OP_COUNT_INIT = 16'h0000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [1:0]     req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [1:0]     req1_op,
    output logic [W-1:0]   log_a,
    output logic [W-1:0]   log_b,
    output logic           log_op0,
    output logic           log_op1,
    input  logic [W-1:0]   log_result,
    output logic           rsp0_valid,
    output logic [W-1:0]   rsp0_data,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    output logic [W-1:0]   rsp1_data,
    input  logic           rsp1_ready,
    output logic           busy,
    output logic [15:0]    op_count,
    output log_arb_state_e fsm_state
);

    log_arb_state_e state_q;
    log_arb_state_e state_d;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   result_q;
    logic [1:0]     ctl_q;
    logic           owner_q;
    logic           last_grant_q;
    logic [15:0]    op_count_q;
    logic           grant_valid;
    logic           grant_id;
    logic           accept;
    logic           complete;
    logic           owner_ready;

    log_rr_pick u_pick (
        .valids      ({req1_valid, req0_valid}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

    // Next-state and handshake decode; ready is held low while reset is asserted.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        complete   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid && rst_n) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (owner_ready) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, op and owner capture on accept; last_grant starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            ctl_q        <= 2'b00;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            a_q          <= grant_id ? req1_a : req0_a;
            b_q          <= grant_id ? req1_b : req0_b;
            ctl_q        <= alu_ctl(grant_id ? req1_op : req0_op);
            owner_q      <= grant_id;
            last_grant_q <= grant_id;
        end
    end

    // Capture the logic unit's result during the single EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else if (state_q == ST_EXEC) begin
            result_q <= log_result;
        end
    end

    // Completed-operation counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= OP_COUNT_INIT;
        end else if (complete) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign log_a      = a_q;
    assign log_b      = b_q;
    assign log_op0    = ctl_q[0];
    assign log_op1    = ctl_q[1];
    assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
    assign rsp1_valid = (state_q == ST_RESP) && owner_q;
    assign rsp0_data  = result_q;
    assign rsp1_data  = result_q;
    assign busy       = (state_q != ST_IDLE);
    assign op_count   = op_count_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_log_arbiter.sv
// Self-checking bench for log_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_log_arbiter;
    import log_arb_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main DUT signals ----------------
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [1:0]     req0_op, req1_op;
    logic [W-1:0]   log_a, log_b, log_result;
    logic           log_op0, log_op1;
    logic           rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0]   rsp0_data, rsp1_data;
    logic           busy;
    logic [15:0]    op_count;
    log_arb_state_e fsm_state;

    // ---------------- counter-wrap DUT signals ----------------
    logic           w_req0_valid, w_req0_ready, w_req1_ready;
    logic [W-1:0]   w_log_a, w_log_b, w_log_result, w_rsp0_data, w_rsp1_data;
    logic           w_log_op0, w_log_op1, w_rsp0_valid, w_rsp1_valid, w_busy;
    logic [15:0]    w_op_count;
    log_arb_state_e w_fsm_state;

    // ---------------- scoreboard / model state ----------------
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [W-1:0] exp_q[$];
    bit          m_busy;
    int          m_age;
    bit          m_last;
    bit          m_owner;
    logic [W-1:0] m_a, m_b;
    logic [1:0]  m_op;
    logic [15:0] m_count;

    // Shared logic unit: op[1]=AluOp1, op[0]=AluOp0; 00 OR, 10 NOR, 01 AND, 11 XOR.
    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'b00:   return a | b;
            2'b10:   return ~(a | b);
            2'b01:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign log_result   = ref_op({log_op1, log_op0}, log_a, log_b);
    assign w_log_result = ref_op({w_log_op1, w_log_op0}, w_log_a, w_log_b);

    log_arbiter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .log_a(log_a), .log_b(log_b), .log_op0(log_op0), .log_op1(log_op1), .log_result(log_result),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
        .busy(busy), .op_count(op_count), .fsm_state(fsm_state)
    );

    log_arbiter #(.W(W), .OP_COUNT_INIT(16'hFFFE)) wrap_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(w_req0_valid), .req0_ready(w_req0_ready), .req0_a(32'h1234_5678), .req0_b(32'h0F0F_0F0F), .req0_op(2'b11),
        .req1_valid(1'b0), .req1_ready(w_req1_ready), .req1_a('0), .req1_b('0), .req1_op(2'b00),
        .log_a(w_log_a), .log_b(w_log_b), .log_op0(w_log_op0), .log_op1(w_log_op1), .log_result(w_log_result),
        .rsp0_valid(w_rsp0_valid), .rsp0_data(w_rsp0_data), .rsp0_ready(1'b1),
        .rsp1_valid(w_rsp1_valid), .rsp1_data(w_rsp1_data), .rsp1_ready(1'b1),
        .busy(w_busy), .op_count(w_op_count), .fsm_state(w_fsm_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge with inputs set: checks outputs against the model,
    // advances the model across the next rising edge, returns at the next negedge.
    task automatic tick();
        logic [1:0] v;
        bit         acc;
        bit         gid;
        bit         own_rdy;
        logic [W-1:0] ga, gb;
        logic [1:0] gop;
        #1;
        v   = {req1_valid, req0_valid};
        acc = 1'b0;
        gid = 1'b0;
        check("busy", busy, m_busy);
        check("op_count", op_count, m_count);
        if (!m_busy) begin
            gid = (v == 2'b11) ? ~m_last : v[1];
            acc = (v != 2'b00);
            check("req0_ready", req0_ready, acc && !gid);
            check("req1_ready", req1_ready, acc && gid);
            check("rsp0_valid_idle", rsp0_valid, 1'b0);
            check("rsp1_valid_idle", rsp1_valid, 1'b0);
        end else begin
            check("req0_ready_busy", req0_ready, 1'b0);
            check("req1_ready_busy", req1_ready, 1'b0);
            if (m_age == 1) begin
                check("log_a", log_a, m_a);
                check("log_b", log_b, m_b);
                check("log_op", {log_op1, log_op0}, m_op);
                check("rsp0_valid_exec", rsp0_valid, 1'b0);
                check("rsp1_valid_exec", rsp1_valid, 1'b0);
            end else begin
                check("rsp0_valid", rsp0_valid, !m_owner);
                check("rsp1_valid", rsp1_valid, m_owner);
                check("rsp_data", m_owner ? rsp1_data : rsp0_data, exp_q[0]);
            end
        end
        own_rdy = m_owner ? rsp1_ready : rsp0_ready;
        ga  = gid ? req1_a : req0_a;
        gb  = gid ? req1_b : req0_b;
        gop = gid ? req1_op : req0_op;
        @(posedge clk);
        if (acc) begin
            m_busy  = 1'b1;
            m_age   = 1;
            m_last  = gid;
            m_owner = gid;
            m_a     = ga;
            m_b     = gb;
            m_op    = gop;
            exp_q.push_back(ref_op(gop, ga, gb));
        end else if (m_busy) begin
            if (m_age == 1) begin
                m_age = 2;
            end else if (own_rdy) begin
                m_busy  = 1'b0;
                m_count = m_count + 16'd1;
                void'(exp_q.pop_front());
            end
        end
        @(negedge clk);
    endtask

    // Asserts reset at a negedge, checks outputs clear immediately, releases at the next negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_req1_ready", req1_ready, 1'b0);
        check("rst_rsp0_valid", rsp0_valid, 1'b0);
        check("rst_rsp1_valid", rsp1_valid, 1'b0);
        check("rst_log_a", log_a, '0);
        check("rst_log_b", log_b, '0);
        check("rst_log_op", {log_op1, log_op0}, 2'b00);
        check("rst_rsp_data", rsp0_data | rsp1_data, '0);
        check("rst_op_count", op_count, 16'h0000);
        m_busy  = 1'b0;
        m_age   = 0;
        m_last  = 1'b1;
        m_owner = 1'b0;
        m_count = 16'h0000;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one isolated operation on channel ch and checks its response against a constant.
    task automatic run_op(input bit ch, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input logic [W-1:0] exp, input string tag);
        if (ch) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        #1;
        check({tag, "_valid"}, ch ? rsp1_valid : rsp0_valid, 1'b1);
        check(tag, ch ? rsp1_data : rsp0_data, exp);
        tick();
    endtask

    // ---------------- stimulus ----------------
    logic [1:0]   ops_tab[4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [W-1:0] res_tab[4] = '{32'hFFFF_5555, 32'h0000_AAAA, 32'hAAAA_0000, 32'h5555_5555};

    initial begin
        rst_n        = 1'b0;
        req0_valid   = 1'b0; req0_a = '0; req0_b = '0; req0_op = 2'b00;
        req1_valid   = 1'b0; req1_a = '0; req1_b = '0; req1_op = 2'b00;
        rsp0_ready   = 1'b1;
        rsp1_ready   = 1'b1;
        w_req0_valid = 1'b0;
        @(negedge clk);
        do_reset();

        // Single AND on requester 0, response two cycles after the accept cycle.
        run_op(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b01, 32'h00F0_00F0, "single_and");
        #1;
        check("single_count", op_count, 16'd1);
        @(negedge clk);

        // Every op encoding on requester 1.
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, 32'hAAAA_5555, 32'hFFFF_0000, ops_tab[i], res_tab[i], "all_ops");
        end

        // Tie from reset: grants alternate 0,1,0,1.
        req0_valid = 1'b1; req1_valid = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req0_a = 32'h1000_0000 + k; req0_b = 32'h0000_FFFF; req0_op = 2'b11;
            req1_a = 32'h2000_0000 + k; req1_b = 32'hFFFF_0000; req1_op = 2'b00;
            #1;
            check("tie_grant", {req1_ready, req0_ready}, (k % 2 == 1) ? 2'b10 : 2'b01);
            tick(); tick(); tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Backpressure on requester 1 while requester 0 waits.
        req1_valid = 1'b1; req1_a = 32'hDEAD_BEEF; req1_b = 32'h0F0F_F0F0; req1_op = 2'b10;
        rsp1_ready = 1'b0;
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h0000_00FF; req0_b = 32'h0000_0F0F; req0_op = 2'b01;
        for (int k = 0; k < 6; k++) tick();
        rsp1_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick(); tick(); tick();

        // Reset in EXEC: nothing comes back, next tie goes to requester 0.
        req0_valid = 1'b1; req0_a = 32'h5A5A_5A5A; req0_b = 32'hFFFF_FFFF; req0_op = 2'b11;
        tick();
        req1_valid = 1'b1;
        do_reset();
        #1;
        check("post_reset_grant", {req1_ready, req0_ready}, 2'b01);
        tick(); tick(); tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_a = $urandom; req0_b = $urandom; req0_op = 2'($urandom_range(0, 3));
            req1_a = $urandom; req1_b = $urandom; req1_op = 2'($urandom_range(0, 3));
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int n = 0; n < 4; n++) tick();

        // Counter wrap on the preloaded instance.
        do_reset();
        #1;
        check("wrap_init", w_op_count, 16'hFFFE);
        w_req0_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("wrap_ffff", w_op_count, 16'hFFFF);
        check("wrap_rsp_data", w_rsp0_data, 32'h1D3B_5977);
        repeat (3) @(negedge clk);
        #1;
        check("wrap_zero", w_op_count, 16'h0000);
        w_req0_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
